// File: rtl/uart_vector_player_if.sv
// uart_vector_player_if
//   Bundles the received byte stream and the display-side outputs of the
//   vector player.
//   master : drives rx_data/rx_valid, observes the DAC samples and status.
//   slave  : the player; consumes the byte stream, drives xdac, ydac,
//            frame_active, point_count, busy and err.
interface uart_vector_player_if #(
   parameter int unsigned MAX_POINTS = 32
);
   localparam int unsigned CW = $clog2(MAX_POINTS + 1);

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [7:0]    xdac;
   logic [7:0]    ydac;
   logic          frame_active;
   logic [CW-1:0] point_count;
   logic          busy;
   logic          err;

   modport master (
      output rx_data, rx_valid,
      input  xdac, ydac, frame_active, point_count, busy, err
   );

   modport slave (
      input  rx_data, rx_valid,
      output xdac, ydac, frame_active, point_count, busy, err
   );
endinterface

// File: rtl/uart_vector_player.sv
// uart_vector_player
//   Parses framed point lists (A5, N, N x {X,Y}, XOR checksum) from the UART
//   byte stream into the shadow half of a double-buffered point memory and
//   replays the active half to the X/Y DACs, each point held DWELL_CYCLES
//   cycles. A validated list swaps in only when the last point of the playing
//   list finishes, or on the next edge when nothing is playing.
//   clk   : single clock
//   reset : asynchronous, active-high
//   bus   : slave side of uart_vector_player_if (byte stream in, DAC/status out)
module uart_vector_player #(
   parameter int unsigned MAX_POINTS   = 32,
   parameter int unsigned DWELL_CYCLES = 4
) (
   input logic                 clk,
   input logic                 reset,
   uart_vector_player_if.slave bus
);
   localparam int unsigned    CW        = $clog2(MAX_POINTS + 1);
   localparam int unsigned    IW        = $clog2(MAX_POINTS);
   localparam int unsigned    DWW       = $clog2(DWELL_CYCLES + 1);
   localparam logic [DWW-1:0] DwellLast = DWW'(DWELL_CYCLES - 1);
   localparam logic [7:0]     Header    = 8'hA5;

   typedef enum logic [2:0] {StIdle, StCount, StXb, StYb, StCsum} state_e;

   // Parser state
   state_e        state_q;
   logic [CW-1:0] n_q;
   logic [CW-1:0] wr_idx_q;
   logic [7:0]    x_q;
   logic [7:0]    csum_q;
   logic          busy_q;
   logic          err_q;

   // Playback state
   logic           frame_active_q;
   logic           bank_q;          // bank being played; the other one is the shadow
   logic [CW-1:0]  point_count_q;
   logic [CW-1:0]  rd_idx_q;        // index of the point to load at the next boundary
   logic [DWW-1:0] dwell_q;
   logic [7:0]     xdac_q;
   logic [7:0]     ydac_q;

   logic [15:0] mem_q [2][MAX_POINTS];
   logic [15:0] rd_data_q;

   logic          csum_ok;
   logic          pt_we;
   logic          boundary;
   logic          swap;
   logic          busy_d;
   logic          bank_d;
   logic          rd_bank;
   logic [CW-1:0] count_sel;
   logic [CW-1:0] rd_idx_inc;
   logic [CW-1:0] rd_idx_d;

   assign csum_ok = (state_q == StCsum) && bus.rx_valid && (bus.rx_data == csum_q);
   assign pt_we   = (state_q == StYb) && bus.rx_valid;

   always_comb begin
      boundary   = frame_active_q && (dwell_q == DwellLast);
      // rd_idx_q == 0 at a boundary means the last point's dwell is ending
      swap       = busy_q && (!frame_active_q || (boundary && (rd_idx_q == '0)));
      count_sel  = swap ? n_q : point_count_q;
      bank_d     = swap ? ~bank_q : bank_q;
      busy_d     = csum_ok | (busy_q & ~swap);
      rd_idx_inc = rd_idx_q + CW'(1);
      rd_idx_d   = rd_idx_q;
      if (swap && !frame_active_q) begin
         rd_idx_d = '0;
      end else if (boundary) begin
         rd_idx_d = (rd_idx_inc == count_sel) ? '0 : rd_idx_inc;
      end
      // Prefetch point 0 of the pending list whenever the next load would be
      // the swap, so the new frame starts exactly on the dwell boundary.
      rd_bank = (busy_d && (rd_idx_d == '0)) ? ~bank_d : bank_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         n_q      <= '0;
         wr_idx_q <= '0;
         x_q      <= '0;
         csum_q   <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q  <= 1'b0;
         busy_q <= busy_d;
         if (bus.rx_valid) begin
            unique case (state_q)
               StIdle: begin
                  if (!busy_q && (bus.rx_data == Header)) state_q <= StCount;
               end
               StCount: begin
                  if ((bus.rx_data != 8'h00) && (bus.rx_data <= 8'(MAX_POINTS))) begin
                     n_q      <= bus.rx_data[CW-1:0];
                     csum_q   <= bus.rx_data;
                     wr_idx_q <= '0;
                     state_q  <= StXb;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= StIdle;
                  end
               end
               StXb: begin
                  x_q     <= bus.rx_data;
                  csum_q  <= csum_q ^ bus.rx_data;
                  state_q <= StYb;
               end
               StYb: begin
                  csum_q   <= csum_q ^ bus.rx_data;
                  wr_idx_q <= wr_idx_q + CW'(1);
                  state_q  <= ((wr_idx_q + CW'(1)) == n_q) ? StCsum : StXb;
               end
               StCsum: begin
                  err_q   <= !csum_ok;
                  state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // Point memory is never cleared; it is only read after a commit.
   always_ff @(posedge clk) begin
      if (pt_we) mem_q[~bank_q][wr_idx_q[IW-1:0]] <= {x_q, bus.rx_data};
      rd_data_q <= mem_q[rd_bank][rd_idx_d[IW-1:0]];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_active_q <= 1'b0;
         bank_q         <= 1'b0;
         point_count_q  <= '0;
         rd_idx_q       <= '0;
         dwell_q        <= '0;
         xdac_q         <= 8'h80;
         ydac_q         <= 8'h80;
      end else begin
         bank_q   <= bank_d;
         rd_idx_q <= rd_idx_d;
         if (swap) begin
            frame_active_q <= 1'b1;
            point_count_q  <= n_q;
         end
         if (swap && !frame_active_q) begin
            // Force a boundary on the next edge so point 0 loads then.
            dwell_q <= DwellLast;
         end else if (boundary) begin
            dwell_q          <= '0;
            {xdac_q, ydac_q} <= rd_data_q;
         end else if (frame_active_q) begin
            dwell_q <= dwell_q + DWW'(1);
         end
      end
   end

   assign bus.xdac         = xdac_q;
   assign bus.ydac         = ydac_q;
   assign bus.frame_active = frame_active_q;
   assign bus.point_count  = point_count_q;
   assign bus.busy         = busy_q;
   assign bus.err          = err_q;
endmodule
